// File: rtl/amm_slave_responder.sv
// -----------------------------------------------------------------------------
// amm_slave_responder
//
// Avalon-MM slave that stands in for external memory during self-test and
// bring-up. It stores write bursts (byteenable-masked) into an internal RAM,
// answers read bursts with a fixed latency, and inserts periodic waitrequest
// stalls so the master's handshake logic gets exercised.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   address_i       burst start address (byte or word addressing, ADDR_TYPE)
//   read_i          read command
//   write_i         write beat
//   writedata_i     write data
//   burstcount_i    beats in the burst (0 is treated as 1)
//   byteenable_i    per-byte write mask
//   waitrequest_o   slave stall (combinational)
//   readdata_o      read data (registered)
//   readdatavalid_o read data qualifier (registered)
//   proto_err_o     sticky protocol-violation flag (registered)
//
// Optional feature (macro AMM_RESP_ERR_INJ_EN):
//   err_en_i        enable read-data corruption
//   err_addr_i      word index whose read beats return bit 0 inverted
// -----------------------------------------------------------------------------
module amm_slave_responder #(
    parameter int    AMM_ADDR_W   = 31,
    parameter int    AMM_DATA_W   = 64,
    parameter int    AMM_BURST_W  = 11,
    parameter string ADDR_TYPE    = "BYTE",
    parameter int    MEM_WORDS_W  = 10,
    parameter int    READ_LATENCY = 2,
    parameter int    WAIT_PERIOD  = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AMM_ADDR_W-1:0]     address_i,
    input  logic                      read_i,
    input  logic                      write_i,
    input  logic [AMM_DATA_W-1:0]     writedata_i,
    input  logic [AMM_BURST_W-1:0]    burstcount_i,
    input  logic [AMM_DATA_W/8-1:0]   byteenable_i,
`ifdef AMM_RESP_ERR_INJ_EN
    input  logic                      err_en_i,
    input  logic [MEM_WORDS_W-1:0]    err_addr_i,
`endif
    output logic                      waitrequest_o,
    output logic [AMM_DATA_W-1:0]     readdata_o,
    output logic                      readdatavalid_o,
    output logic                      proto_err_o
);

    localparam int DATA_B_W  = AMM_DATA_W / 8;
    localparam int ADDR_B_W  = $clog2(DATA_B_W);
    localparam int MEM_DEPTH = 1 << MEM_WORDS_W;
    localparam int CNT_W     = AMM_BURST_W + $clog2(READ_LATENCY) + 1;
    localparam int SC_W      = (WAIT_PERIOD > 1) ? $clog2(WAIT_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                  state_reg, state_next;
    logic [MEM_WORDS_W-1:0]  ptr_reg, ptr_next;       // next word to write / read
    logic [AMM_BURST_W-1:0]  beats_reg, beats_next;   // writes left, or reads left to issue
    logic [CNT_W-1:0]        rd_cnt_reg, rd_cnt_next; // cycles left in the read window
    logic                    proto_err_reg;
    logic                    vld0_reg;                // aligned with RAM read register

    logic                    stall;
    logic                    accept;
    logic                    mem_we;
    logic [MEM_WORDS_W-1:0]  mem_waddr;
    logic                    issue;
    logic [AMM_DATA_W-1:0]   ram_q;
    logic [AMM_DATA_W-1:0]   flip_mask;
    logic [AMM_ADDR_W-1:0]   addr_word;
    logic [MEM_WORDS_W-1:0]  word_idx;
    logic [AMM_BURST_W-1:0]  bc_eff;
    logic                    unused_addr_bits;

    // ---------------- address decode ----------------
    if (ADDR_TYPE == "BYTE") begin : g_byte_addr
        assign addr_word = address_i >> ADDR_B_W;
    end else begin : g_word_addr
        assign addr_word = address_i;
    end
    assign word_idx         = addr_word[MEM_WORDS_W-1:0];
    assign unused_addr_bits = ^addr_word[AMM_ADDR_W-1:MEM_WORDS_W];
    assign bc_eff           = (burstcount_i == '0) ? AMM_BURST_W'(1) : burstcount_i;

    // ---------------- stall generator ----------------
    if (WAIT_PERIOD == 0) begin : g_no_stall
        assign stall = 1'b0;
    end else begin : g_stall
        logic [SC_W-1:0] stall_cnt_reg;
        always_ff @(posedge clk_i) begin
            if (rst_i)
                stall_cnt_reg <= '0;
            else if (stall_cnt_reg == SC_W'(WAIT_PERIOD - 1))
                stall_cnt_reg <= '0;
            else
                stall_cnt_reg <= stall_cnt_reg + SC_W'(1);
        end
        assign stall = (stall_cnt_reg == SC_W'(WAIT_PERIOD - 1));
    end

    assign waitrequest_o = rst_i | (state_reg == RD_BURST) | stall;
    assign accept        = (read_i | write_i) & ~waitrequest_o;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            beats_reg  <= '0;
            rd_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            beats_reg  <= beats_next;
            rd_cnt_reg <= rd_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        beats_next  = beats_reg;
        rd_cnt_next = rd_cnt_reg;
        mem_we      = 1'b0;
        mem_waddr   = ptr_reg;
        issue       = 1'b0;
        case (state_reg)
            IDLE: begin
                // write has priority over a simultaneous read
                if (accept && write_i) begin
                    mem_we     = 1'b1;
                    mem_waddr  = word_idx;
                    ptr_next   = word_idx + MEM_WORDS_W'(1);
                    beats_next = bc_eff - AMM_BURST_W'(1);
                    if (bc_eff > AMM_BURST_W'(1))
                        state_next = WR_BURST;
                end else if (accept && read_i) begin
                    ptr_next    = word_idx;
                    beats_next  = bc_eff;
                    // window covers the issue cycles plus the pipeline drain
                    rd_cnt_next = CNT_W'(READ_LATENCY) + CNT_W'(bc_eff) - CNT_W'(1);
                    state_next  = RD_BURST;
                end
            end
            WR_BURST: begin
                if (accept && write_i) begin
                    mem_we     = 1'b1;
                    ptr_next   = ptr_reg + MEM_WORDS_W'(1);
                    beats_next = beats_reg - AMM_BURST_W'(1);
                    if (beats_reg == AMM_BURST_W'(1))
                        state_next = IDLE;
                end
            end
            RD_BURST: begin
                if (beats_reg != '0) begin
                    issue      = 1'b1;
                    ptr_next   = ptr_reg + MEM_WORDS_W'(1);
                    beats_next = beats_reg - AMM_BURST_W'(1);
                end
                rd_cnt_next = rd_cnt_reg - CNT_W'(1);
                if (rd_cnt_reg == CNT_W'(1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- protocol checker ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i)
            proto_err_reg <= 1'b0;
        else if ((read_i && write_i) ||
                 (read_i && state_reg == WR_BURST) ||
                 (write_i && state_reg == RD_BURST))
            proto_err_reg <= 1'b1;
    end
    assign proto_err_o = proto_err_reg;

    // ---------------- memory ----------------
`ifdef AMM_RESP_ERR_INJ_EN
    // corruption is applied on the way out so the stored word stays intact
    assign flip_mask = {{(AMM_DATA_W-1){1'b0}}, err_en_i && (ptr_reg == err_addr_i)};
`else
    assign flip_mask = '0;
`endif

    // one RAM per byte lane keeps the byteenable write a plain lane write-enable
    for (genvar gi = 0; gi < DATA_B_W; gi++) begin : g_lane
        logic [7:0] lane_mem [0:MEM_DEPTH-1];
        logic [7:0] lane_q_reg;

        always_ff @(posedge clk_i) begin
            if (mem_we && byteenable_i[gi])
                lane_mem[mem_waddr] <= writedata_i[8*gi +: 8];
        end

        always_ff @(posedge clk_i) begin
            if (rst_i)
                lane_q_reg <= '0;
            else if (issue)
                lane_q_reg <= lane_mem[ptr_reg] ^ flip_mask[8*gi +: 8];
        end

        assign ram_q[8*gi +: 8] = lane_q_reg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            vld0_reg <= 1'b0;
        else
            vld0_reg <= issue;
    end

    // ---------------- extra latency stages ----------------
    if (READ_LATENCY == 2) begin : g_lat2
        assign readdata_o      = ram_q;
        assign readdatavalid_o = vld0_reg;
    end else begin : g_latn
        localparam int EXTRA = READ_LATENCY - 2;
        logic [AMM_DATA_W-1:0] dat_pipe_reg [0:EXTRA-1];
        logic [EXTRA-1:0]      vld_pipe_reg;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_pipe_reg <= '0;
                for (int i = 0; i < EXTRA; i++)
                    dat_pipe_reg[i] <= '0;
            end else begin
                vld_pipe_reg[0] <= vld0_reg;
                dat_pipe_reg[0] <= ram_q;
                for (int i = 1; i < EXTRA; i++) begin
                    vld_pipe_reg[i] <= vld_pipe_reg[i-1];
                    dat_pipe_reg[i] <= dat_pipe_reg[i-1];
                end
            end
        end

        assign readdata_o      = dat_pipe_reg[EXTRA-1];
        assign readdatavalid_o = vld_pipe_reg[EXTRA-1];
    end

endmodule

// File: doc/amm_slave_responder.md
# amm_slave_responder

Synthesizable Avalon-MM slave that terminates the memory checker's AMM master port for self-test and bring-up without external memory. It stores write bursts with byteenable masking, returns read bursts with fixed latency, and inserts deterministic waitrequest stalls to exercise the master's handshake logic. It sits where the DDR/SRAM controller normally connects, on the far side of the transmitter block.

## Interface
- AMM_ADDR_W, 31: address width.
- AMM_DATA_W, 64: data width, multiple of 8; DATA_B_W = AMM_DATA_W/8, ADDR_B_W = log2(DATA_B_W).
- AMM_BURST_W, 11: burstcount width.
- ADDR_TYPE, "BYTE": "BYTE" means word index = address_i >> ADDR_B_W; "WORD" means address_i is the word index.
- MEM_WORDS_W, 10: internal memory depth is 2^MEM_WORDS_W words.
- READ_LATENCY, 2: cycles from read-command acceptance to the first readdatavalid_o; must be 2 or more.
- WAIT_PERIOD, 5: stall period; 0 means no stalls; 1 is illegal.
- clk_i, input, 1: clock.
- rst_i, input, 1: reset; one clock; reset is synchronous and active-high.
- address_i, input, AMM_ADDR_W: burst start address.
- read_i, input, 1: read command.
- write_i, input, 1: write beat.
- writedata_i, input, AMM_DATA_W: write data.
- burstcount_i, input, AMM_BURST_W: beats in the burst.
- byteenable_i, input, DATA_B_W: per-byte write mask.
- waitrequest_o, output, 1: slave stall.
- readdata_o, output, AMM_DATA_W: read data.
- readdatavalid_o, output, 1: read data qualifier.
- proto_err_o, output, 1: sticky protocol-violation flag.

## Operation
- Registered state machine with states IDLE, WR_BURST and RD_BURST. All internal state resets to IDLE.
- Accept rule: a beat or command is accepted only in a cycle where (read_i or write_i) is high and waitrequest_o is low.
- Waitrequest:
  - waitrequest_o = rst_i OR rd_busy OR stall.
  - stall_cnt is a free-running counter, 0..WAIT_PERIOD-1. stall is high when stall_cnt == WAIT_PERIOD-1.
  - With WAIT_PERIOD = 0, stall is constant 0.
- IDLE, write_i accepted:
  - Latch the word index modulo 2^MEM_WORDS_W and the beat count.
  - A burstcount_i of 0 is treated as 1.
  - Store beat 0.
  - If the beat count is greater than 1, go to WR_BURST; otherwise stay in IDLE.
- WR_BURST:
  - Each accepted write_i beat writes to the next sequential word index, wrapping at 2^MEM_WORDS_W.
  - Only bytes with byteenable_i set are modified.
  - address_i and burstcount_i are ignored on later beats.
  - Return to IDLE after the final beat.
- IDLE, read_i accepted:
  - Latch the word index and the beat count (0 treated as 1).
  - Set rd_busy and go to RD_BURST.
  - Issue one memory read per cycle, sequential and wrapping.
  - Return the data as consecutive readdatavalid_o beats.
  - Clear rd_busy and return to IDLE in the cycle after the last beat.
- proto_err_o is set and held until reset when any of the following occurs:
  - read_i and write_i are high together (write wins and the read is dropped).
  - read_i is high in WR_BURST.
  - write_i is high in RD_BURST.
- Reset mid-burst:
  - The burst is abandoned and in-flight readdatavalid_o beats are squashed.
  - Memory contents are preserved; the RAM is not cleared.
- Reset values: waitrequest_o 1 (while rst_i is high), readdatavalid_o 0, readdata_o 0, proto_err_o 0, stall_cnt 0.

## Timing
- Write: an accepted beat at cycle T is visible to a memory read issued at T+1 or later.
- Read accepted at cycle T:
  - Beat k has readdatavalid_o at T+READ_LATENCY+k, for k = 0..N-1.
  - waitrequest_o stays high from T+1 through T+READ_LATENCY+N-1.
  - The earliest next acceptance is T+READ_LATENCY+N, subject to stall.
- A stall cycle never delays readdatavalid_o beats that are already in flight.
- The first cycle after rst_i falls has waitrequest_o = 0, unless WAIT_PERIOD = 1 (illegal).
- All outputs except waitrequest_o are registered.

## Configuration
- AMM_RESP_ERR_INJ_EN defined:
  - Adds input ports err_en_i (1 bit) and err_addr_i (MEM_WORDS_W bits).
  - Each read beat whose word index equals err_addr_i while err_en_i is high returns readdata_o with bit 0 inverted. Memory contents are unchanged.
- AMM_RESP_ERR_INJ_EN undefined: these ports are absent and read data is always the exact stored value.

## Test plan
- Write/read back: WAIT_PERIOD=0, ADDR_TYPE="BYTE", DATA_B_W=8. Write 4 beats of 0x5555…, 0xAAAA…, 0x0F0F…, 0xF0F0… to address 0x100 (word 0x20), then read burstcount 4 at 0x100 -> readdatavalid_o in cycles T+2..T+5 with the same values in order; proto_err_o=0.
- Byteenable masking: write all-ones to word 7, then write 0 with byteenable 8'h0F, then read word 7 -> 0xFFFFFFFF00000000.
- Stall insertion: WAIT_PERIOD=5 with write_i held high for 10 beats -> waitrequest_o high exactly every 5th cycle; all 10 words stored; master retries handled.
- Wrap: MEM_WORDS_W=4, write 4 beats at word 14, read 4 at word 14 -> words 14, 15, 0, 1 returned in order.
- Protocol error and reset: assert read_i with write_i -> write stored and proto_err_o=1 until reset. Assert rst_i mid read burst -> readdatavalid_o is 0 the next cycle and earlier data is still readable after reset.
- AMM_RESP_ERR_INJ_EN: with err_en_i=1 and err_addr_i=3, read words 2..4 containing 0x00 -> word 3 returns 0x…01; words 2 and 4 return 0.
